// File: rtl/seg7_scan_capture.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : seg7_scan_capture                                            |
// | Description : Snoops a multiplexed 7-segment bus (segment lines plus       |
// |               one-hot digit select), waits for each digit's pattern to     |
// |               settle, decodes it back to BCD and reports per-digit         |
// |               captures and frame completion.                               |
// | Options     : SEG_ACTIVE_LOW_EN - invert seg at the input register for     |
// |               common-anode (active-low) segment drive.                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module seg7_scan_capture #(
  parameter int N_DIG      = 4,
  parameter int STABLE_CYC = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           seg,
  input  logic [N_DIG-1:0]     dig_sel,
  output logic [4*N_DIG-1:0]   digits,
  output logic [N_DIG-1:0]     dig_valid,
  output logic [N_DIG-1:0]     dig_err,
  output logic                 upd,
  output logic [7:0]           upd_idx,
  output logic                 frame
);

  // FSM encoding
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;

  localparam logic [7:0]       STABLE_LIM = 8'(STABLE_CYC);
  localparam logic [N_DIG-1:0] ALL_SEEN   = '1;

  // Map a segment pattern to {error, code}. Blank shows as E, anything
  // unrecognised as F with the error flag. 0x07 is always 7: the encoder's
  // out-of-range default looks identical on the glass.
  function automatic logic [4:0] seg_decode(input logic [6:0] pat);
    logic [4:0] r;
    case (pat)
      7'h3F:   r = {1'b0, 4'd0};
      7'h06:   r = {1'b0, 4'd1};
      7'h5B:   r = {1'b0, 4'd2};
      7'h4F:   r = {1'b0, 4'd3};
      7'h66:   r = {1'b0, 4'd4};
      7'h6D:   r = {1'b0, 4'd5};
      7'h7D:   r = {1'b0, 4'd6};
      7'h07:   r = {1'b0, 4'd7};
      7'h7F:   r = {1'b0, 4'd8};
      7'h6F:   r = {1'b0, 4'd9};
      7'h00:   r = {1'b0, 4'hE};
      default: r = {1'b1, 4'hF};
    endcase
    return r;
  endfunction

  logic [6:0]       seg_in;
  logic [6:0]       s_seg;
  logic [N_DIG-1:0] s_sel;
  logic [6:0]       p_seg;
  logic [N_DIG-1:0] p_sel;

  logic [1:0]       state;
  logic [1:0]       state_nx;
  logic [7:0]       cnt;
  logic [7:0]       cnt_nx;

  logic             sel_onehot;
  logic             pair_changed;
  logic             settle_done;
  logic             capture;
  logic [7:0]       cap_idx;
  logic [4:0]       cap_dec;
  logic [N_DIG-1:0] seen;
  logic [N_DIG-1:0] seen_nx;

`ifdef SEG_ACTIVE_LOW_EN
  // Common-anode boards drive lit segments low; fold that away here so
  // every later rule sees active-high patterns.
  assign seg_in = ~seg;
`else
  assign seg_in = seg;
`endif

  // Input register plus a one-sample history used for change detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_seg <= '0;
      s_sel <= '0;
      p_seg <= '0;
      p_sel <= '0;
    end else begin
      s_seg <= seg_in;
      s_sel <= dig_sel;
      p_seg <= s_seg;
      p_sel <= s_sel;
    end
  end

  // Classify the registered sample: one-hot select and change since last sample.
  always_comb begin
    sel_onehot   = (s_sel != '0) && ((s_sel & (s_sel - 1'b1)) == '0);
    pair_changed = ({s_seg, s_sel} != {p_seg, p_sel});
  end

  // Stability count: restarts on any change or on leaving IDLE, saturates at the limit.
  always_comb begin
    cnt_nx = cnt;
    if ((state == ST_IDLE) || pair_changed) begin
      cnt_nx = 8'd1;
    end else if (cnt < STABLE_LIM) begin
      cnt_nx = cnt + 8'd1;
    end
    settle_done = (cnt_nx >= STABLE_LIM);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (sel_onehot) begin
          state_nx = settle_done ? ST_HOLD : ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (!sel_onehot) begin
          state_nx = ST_IDLE;
        end else if (settle_done) begin
          state_nx = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (!sel_onehot) begin
          state_nx = ST_IDLE;
        end else if (pair_changed) begin
          state_nx = settle_done ? ST_HOLD : ST_SETTLE;
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // FSM output logic: a capture fires once per stable one-hot run.
  always_comb begin
    capture = 1'b0;
    case (state)
      ST_IDLE:   capture = sel_onehot && settle_done;
      ST_SETTLE: capture = sel_onehot && settle_done;
      ST_HOLD:   capture = sel_onehot && pair_changed && settle_done;
      default:   capture = 1'b0;
    endcase
  end

  // Counter register; parked at zero while idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (state_nx == ST_IDLE) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nx;
    end
  end

  // Index of the selected digit and the decoded pattern for the capture path.
  always_comb begin
    cap_idx = '0;
    for (int i = 0; i < N_DIG; i++) begin
      if (s_sel[i]) begin
        cap_idx = 8'(i);
      end
    end
    cap_dec = seg_decode(s_seg);
  end

  // Seen mask including the current capture; all-ones completes a frame.
  always_comb begin
    seen_nx = seen;
    if (capture) begin
      seen_nx = seen | s_sel;
    end
  end

  // Capture registers, update pulse and frame tracking.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      digits    <= '1;
      dig_valid <= '0;
      dig_err   <= '0;
      upd       <= 1'b0;
      upd_idx   <= '0;
      frame     <= 1'b0;
      seen      <= '0;
    end else begin
      upd   <= capture;
      frame <= 1'b0;
      if (capture) begin
        upd_idx <= cap_idx;
        for (int i = 0; i < N_DIG; i++) begin
          if (s_sel[i]) begin
            digits[4*i +: 4] <= cap_dec[3:0];
            dig_valid[i]     <= 1'b1;
            dig_err[i]       <= cap_dec[4];
          end
        end
      end
      if (seen_nx == ALL_SEEN) begin
        frame <= 1'b1;
        seen  <= '0;
      end else begin
        seen  <= seen_nx;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_capture.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_seg7_scan_capture                                         |
// | Description : Self-checking bench for seg7_scan_capture with a run-length  |
// |               reference model of the capture rules.                        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_seg7_scan_capture;

  localparam int N_DIG      = 4;
  localparam int STABLE_CYC = 4;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [6:0]           seg = '0;
  logic [N_DIG-1:0]     dig_sel = '0;
  logic [4*N_DIG-1:0]   digits;
  logic [N_DIG-1:0]     dig_valid;
  logic [N_DIG-1:0]     dig_err;
  logic                 upd;
  logic [7:0]           upd_idx;
  logic                 frame;

  seg7_scan_capture #(.N_DIG(N_DIG), .STABLE_CYC(STABLE_CYC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seg       (seg),
    .dig_sel   (dig_sel),
    .digits    (digits),
    .dig_valid (dig_valid),
    .dig_err   (dig_err),
    .upd       (upd),
    .upd_idx   (upd_idx),
    .frame     (frame)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Digit glyphs 0..9
  logic [6:0] PAT [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                            7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  // Reference model state
  logic [3:0]       m_dig [N_DIG];
  logic [N_DIG-1:0] m_val, m_err, m_seen;
  logic             e_upd, e_frame;
  int               e_idx;
  logic             p_cap;
  logic [3:0]       p_code;
  int               p_idx;
  int               run;
  logic             run_valid;
  logic [6:0]       prev_seg;
  logic [N_DIG-1:0] prev_sel;

  // Observations
  int         cyc = 0;
  int         obs_upd = 0;
  int         obs_frame = 0;
  int         last_upd_cyc = 0;
  int         last_frame_cyc = 0;
  logic [7:0] obs_idx = '0;

  function automatic logic [3:0] ref_decode(input logic [6:0] p);
    for (int k = 0; k < 10; k++) begin
      if (p == PAT[k]) return 4'(k);
    end
    if (p == 7'h00) return 4'hE;
    return 4'hF;
  endfunction

  function automatic int sel_index(input logic [N_DIG-1:0] v);
    for (int k = 0; k < N_DIG; k++) begin
      if (v[k]) return k;
    end
    return -1;
  endfunction

  function automatic logic [4*N_DIG-1:0] exp_digits();
    logic [4*N_DIG-1:0] r;
    for (int k = 0; k < N_DIG; k++) r[4*k +: 4] = m_dig[k];
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N_DIG; k++) m_dig[k] = 4'hF;
    m_val = '0; m_err = '0; m_seen = '0;
    e_upd = 1'b0; e_frame = 1'b0; e_idx = 0;
    p_cap = 1'b0; p_code = '0; p_idx = 0;
    run = 0; run_valid = 1'b0;
    prev_seg = '0; prev_sel = '0;
  endtask

  // One clock: drive at negedge, advance the model at posedge, observe #1 later.
  task automatic cycle(input logic [6:0] sv, input logic [N_DIG-1:0] dv, input logic rv);
    @(negedge clk);
`ifdef SEG_ACTIVE_LOW_EN
    seg = ~sv;
`else
    seg = sv;
`endif
    dig_sel = dv;
    rst_n   = rv;
    @(posedge clk);
    cyc++;
    if (!rv) begin
      model_reset();
    end else begin
      e_upd   = p_cap;
      e_frame = 1'b0;
      if (p_cap) begin
        e_idx          = p_idx;
        m_dig[p_idx]   = p_code;
        m_val[p_idx]   = 1'b1;
        m_err[p_idx]   = (p_code == 4'hF);
        m_seen[p_idx]  = 1'b1;
        if (&m_seen) begin
          e_frame = 1'b1;
          m_seen  = '0;
        end
      end
      if (run_valid && sv == prev_seg && dv == prev_sel) begin
        if (run <= STABLE_CYC) run++;
      end else begin
        run = 1;
      end
      run_valid = 1'b1;
      prev_seg  = sv;
      prev_sel  = dv;
      p_cap     = ($countones(dv) == 1) && (run == STABLE_CYC);
      p_code    = ref_decode(sv);
      p_idx     = sel_index(dv);
    end
    #1;
    if (upd === 1'b1) begin
      obs_upd++;
      last_upd_cyc = cyc;
      obs_idx = upd_idx;
    end
    if (frame === 1'b1) begin
      obs_frame++;
      last_frame_cyc = cyc;
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) cycle(7'($urandom), 4'($urandom), 1'b0);
    tests++; if (digits !== 16'hFFFF) begin fails++; $display("FAIL reset_digits got=%h exp=%h", digits, 16'hFFFF); end
    tests++; if (dig_valid !== 4'b0) begin fails++; $display("FAIL reset_valid got=%b exp=0000", dig_valid); end
    tests++; if (dig_err !== 4'b0) begin fails++; $display("FAIL reset_err got=%b exp=0000", dig_err); end
    tests++; if (upd !== 1'b0 || frame !== 1'b0) begin fails++; $display("FAIL reset_pulses upd=%b frame=%b exp=0 0", upd, frame); end
    cycle(7'h00, 4'b0000, 1'b1);
    tests++; if (upd !== 1'b0 || dig_valid !== 4'b0) begin fails++; $display("FAIL reset_release upd=%b valid=%b exp=0 0000", upd, dig_valid); end
  endtask

  task automatic test_single_capture();
    int u0, start;
    cycle(7'h00, 4'b0000, 1'b1);
    u0 = obs_upd;
    start = cyc;
    for (int k = 0; k < 10; k++) cycle(7'h5B, 4'b0010, 1'b1);
    tests++; if (obs_upd - u0 != 1) begin fails++; $display("FAIL single_count got=%0d exp=1", obs_upd - u0); end
    tests++; if (last_upd_cyc - start != STABLE_CYC + 1) begin fails++; $display("FAIL single_latency got=%0d exp=%0d", last_upd_cyc - start, STABLE_CYC + 1); end
    tests++; if (obs_idx !== 8'd1) begin fails++; $display("FAIL single_idx got=%0d exp=1", obs_idx); end
    tests++; if (digits[7:4] !== 4'd2) begin fails++; $display("FAIL single_digit got=%h exp=2", digits[7:4]); end
    tests++; if (dig_valid !== 4'b0010) begin fails++; $display("FAIL single_valid got=%b exp=0010", dig_valid); end
  endtask

  task automatic test_glitch();
    int u0;
    u0 = obs_upd;
    for (int k = 0; k < 3; k++) cycle(7'h06, 4'b0001, 1'b1);
    for (int k = 0; k < 8; k++) cycle(7'h4F, 4'b0001, 1'b1);
    tests++; if (obs_upd - u0 != 1) begin fails++; $display("FAIL glitch_count got=%0d exp=1", obs_upd - u0); end
    tests++; if (digits[3:0] !== 4'd3) begin fails++; $display("FAIL glitch_digit got=%h exp=3", digits[3:0]); end
    tests++; if (obs_idx !== 8'd0) begin fails++; $display("FAIL glitch_idx got=%0d exp=0", obs_idx); end
  endtask

  task automatic test_full_frame();
    int u0, f0;
    logic [6:0] fp [4] = '{7'h3F, 7'h06, 7'h7F, 7'h6F};
    u0 = obs_upd; f0 = obs_frame;
    for (int d = 0; d < 4; d++)
      for (int k = 0; k < 6; k++) cycle(fp[d], 4'(1 << d), 1'b1);
    tests++; if (obs_upd - u0 != 4) begin fails++; $display("FAIL frame_upd_count got=%0d exp=4", obs_upd - u0); end
    tests++; if (obs_frame - f0 != 1) begin fails++; $display("FAIL frame_count got=%0d exp=1", obs_frame - f0); end
    tests++; if (last_frame_cyc != last_upd_cyc) begin fails++; $display("FAIL frame_align got=%0d exp=%0d", last_frame_cyc, last_upd_cyc); end
    tests++; if (digits !== 16'h9810) begin fails++; $display("FAIL frame_digits got=%h exp=9810", digits); end
    // Seen must have cleared: three more captures must not complete a frame.
    f0 = obs_frame;
    for (int d = 0; d < 3; d++)
      for (int k = 0; k < 6; k++) cycle(fp[d], 4'(1 << d), 1'b1);
    tests++; if (obs_frame != f0) begin fails++; $display("FAIL frame_seen_clear got=%0d exp=0", obs_frame - f0); end
  endtask

  task automatic test_error_blank();
    for (int k = 0; k < 6; k++) cycle(7'h01, 4'b0100, 1'b1);
    tests++; if (digits[11:8] !== 4'hF) begin fails++; $display("FAIL err_digit got=%h exp=F", digits[11:8]); end
    tests++; if (dig_err[2] !== 1'b1) begin fails++; $display("FAIL err_flag got=%b exp=1", dig_err[2]); end
    for (int k = 0; k < 6; k++) cycle(7'h00, 4'b0100, 1'b1);
    tests++; if (digits[11:8] !== 4'hE) begin fails++; $display("FAIL blank_digit got=%h exp=E", digits[11:8]); end
    tests++; if (dig_err[2] !== 1'b0) begin fails++; $display("FAIL blank_flag got=%b exp=0", dig_err[2]); end
  endtask

  task automatic test_select_faults();
    int u0;
    u0 = obs_upd;
    for (int k = 0; k < 8; k++) cycle(7'h3F, 4'b0011, 1'b1);
    for (int k = 0; k < 8; k++) cycle(7'h3F, 4'b0000, 1'b1);
    tests++; if (obs_upd != u0) begin fails++; $display("FAIL sel_fault got=%0d exp=0", obs_upd - u0); end
    for (int k = 0; k < 2; k++) cycle(7'h66, 4'b1000, 1'b1);
    cycle(7'h66, 4'b1000, 1'b0);
    u0 = obs_upd;
    for (int k = 0; k < 8; k++) cycle(7'h66, 4'b0000, 1'b1);
    tests++; if (obs_upd != u0) begin fails++; $display("FAIL reset_settle got=%0d exp=0", obs_upd - u0); end
    tests++; if (dig_valid !== 4'b0 || digits !== 16'hFFFF) begin fails++; $display("FAIL reset_settle_state valid=%b digits=%h exp=0000 FFFF", dig_valid, digits); end
  endtask

  task automatic test_random();
    logic [6:0]       sv;
    logic [N_DIG-1:0] dv;
    logic             rv;
    int               len, r;
    for (int n = 0; n < 250; n++) begin
      rv = ($urandom_range(0, 40) != 0);
      r  = $urandom_range(0, 9);
      if (r < 7)       dv = 4'(1 << $urandom_range(0, N_DIG - 1));
      else if (r == 7) dv = '0;
      else             dv = 4'($urandom);
      if ($urandom_range(0, 3) == 0) sv = 7'($urandom);
      else                           sv = PAT[$urandom_range(0, 9)];
      len = rv ? $urandom_range(1, 7) : 1;
      for (int k = 0; k < len; k++) begin
        cycle(sv, dv, rv);
        tests++; if (upd !== e_upd) begin fails++; $display("FAIL rnd_upd cyc=%0d got=%b exp=%b", cyc, upd, e_upd); end
        if (e_upd) begin
          tests++; if (upd_idx !== 8'(e_idx)) begin fails++; $display("FAIL rnd_idx cyc=%0d got=%0d exp=%0d", cyc, upd_idx, e_idx); end
        end
        tests++; if (frame !== e_frame) begin fails++; $display("FAIL rnd_frame cyc=%0d got=%b exp=%b", cyc, frame, e_frame); end
        tests++; if (digits !== exp_digits()) begin fails++; $display("FAIL rnd_digits cyc=%0d got=%h exp=%h", cyc, digits, exp_digits()); end
        tests++; if (dig_valid !== m_val) begin fails++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, dig_valid, m_val); end
        tests++; if (dig_err !== m_err) begin fails++; $display("FAIL rnd_err cyc=%0d got=%b exp=%b", cyc, dig_err, m_err); end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_capture();
    test_glitch();
    test_full_frame();
    test_error_blank();
    test_select_faults();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
